// File: rtl/fx2_fifo_sched.sv
// fx2_fifo_sched: FX2LP slave-FIFO bus scheduler. Time-shares the 16-bit FD
// bus between EP2 OUT reads and EP6 IN writes, with fair alternation when
// both directions want the bus and at most MAX_BURST words per grant.
// Optional macro FX2_SCHED_STATS_EN adds rd_words/wr_words/pkt_count counters.
module fx2_fifo_sched #(
  parameter int MAX_BURST = 256,
  parameter int BURST_W   = 9
) (
  input  logic        CLKOUT,
  input  logic        rst,
  input  logic        FLAGA,
  input  logic        FLAGD,
  output logic        SLRD,
  output logic        SLWR,
  output logic        SLOE,
  output logic        PKTEND,
  output logic [1:0]  FIFOADR,
  input  logic [15:0] fd_in,
  output logic [15:0] fd_out,
  output logic        fd_oe,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready
`ifdef FX2_SCHED_STATS_EN
  ,
  output logic [31:0] rd_words,
  output logic [31:0] wr_words,
  output logic [15:0] pkt_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SEL, S_RD_DATA, S_RD_TURN, S_WR_SEL, S_WR_DATA, S_WR_PKTEND
  } state_t;

  localparam logic [BURST_W-1:0] LP_MAX = BURST_W'(MAX_BURST);

  state_t             r_state, w_next;
  logic               r_last_wr;     // 1 = most recent grant went to EP6 writes
  logic [BURST_W-1:0] r_burst_cnt;
  logic [1:0]         r_fifoadr;     // remembers the address so IDLE keeps it
  logic [15:0]        r_rx_data;
  logic               r_rx_valid;

  logic w_rd_pend, w_wr_pend, w_grant_rd, w_grant_wr;
  logic w_burst_ok, w_rd_fire, w_wr_fire;

  assign w_rd_pend  = FLAGA;
  assign w_wr_pend  = tx_valid & FLAGD;
  // With both pending, the direction not served last time wins.
  assign w_grant_rd = w_rd_pend & (~w_wr_pend | r_last_wr);
  assign w_grant_wr = w_wr_pend & (~w_rd_pend | ~r_last_wr);
  assign w_burst_ok = (r_burst_cnt < LP_MAX);
  // Strobes are gated combinationally so a flag falling this cycle never
  // produces a strobe; a reset cycle drops any strobe in progress.
  assign w_rd_fire  = (r_state == S_RD_DATA) & FLAGA & (~r_rx_valid | rx_ready)
                      & w_burst_ok & ~rst;
  assign w_wr_fire  = (r_state == S_WR_DATA) & tx_valid & FLAGD & w_burst_ok & ~rst;

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

  // Next-state and bus strobe decode.
  always_comb begin
    w_next   = r_state;
    SLRD     = ~w_rd_fire;
    SLWR     = ~w_wr_fire;
    SLOE     = 1'b1;
    PKTEND   = 1'b1;
    fd_oe    = 1'b0;
    fd_out   = tx_data;
    tx_ready = w_wr_fire;
    FIFOADR  = r_fifoadr;
    case (r_state)
      S_IDLE: begin
        if (w_grant_rd)      w_next = S_RD_SEL;
        else if (w_grant_wr) w_next = S_WR_SEL;
      end
      S_RD_SEL: begin
        FIFOADR = 2'b00;
        SLOE    = 1'b0;
        w_next  = S_RD_DATA;
      end
      S_RD_DATA: begin
        FIFOADR = 2'b00;
        SLOE    = 1'b0;
        if (!FLAGA || !w_burst_ok) w_next = S_RD_TURN;
      end
      S_RD_TURN: begin
        // SLOE released, FD floating: dead cycle before any FPGA drive.
        FIFOADR = 2'b00;
        w_next  = S_IDLE;
      end
      S_WR_SEL: begin
        FIFOADR = 2'b10;
        fd_oe   = 1'b1;
        w_next  = S_WR_DATA;
      end
      S_WR_DATA: begin
        FIFOADR = 2'b10;
        fd_oe   = 1'b1;
        if (w_wr_fire && tx_last)                  w_next = S_WR_PKTEND;
        else if (!tx_valid || !FLAGD || !w_burst_ok) w_next = S_IDLE;
      end
      S_WR_PKTEND: begin
        FIFOADR = 2'b10;
        fd_oe   = 1'b1;
        PKTEND  = 1'b0;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register, arbitration memory and per-grant burst counter.
  always_ff @(posedge CLKOUT) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last_wr   <= 1'b1;
      r_burst_cnt <= '0;
      r_fifoadr   <= 2'b00;
    end else begin
      r_state   <= w_next;
      r_fifoadr <= FIFOADR;
      if (r_state == S_IDLE) begin
        r_burst_cnt <= '0;
        if (w_grant_rd)      r_last_wr <= 1'b0;
        else if (w_grant_wr) r_last_wr <= 1'b1;
      end else if (w_rd_fire || w_wr_fire) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
    end
  end

  // One-word rx holding register; it survives any state until consumed.
  always_ff @(posedge CLKOUT) begin
    if (rst) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else if (w_rd_fire) begin
      r_rx_data  <= fd_in;
      r_rx_valid <= 1'b1;
    end else if (rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

`ifdef FX2_SCHED_STATS_EN
  logic [31:0] r_rd_words, r_wr_words;
  logic [15:0] r_pkt_count;

  assign rd_words  = r_rd_words;
  assign wr_words  = r_wr_words;
  assign pkt_count = r_pkt_count;

  // Free-running traffic counters, wrapping naturally.
  always_ff @(posedge CLKOUT) begin
    if (rst) begin
      r_rd_words  <= '0;
      r_wr_words  <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_rd_fire) r_rd_words <= r_rd_words + 32'd1;
      if (w_wr_fire) r_wr_words <= r_wr_words + 32'd1;
      if (r_state == S_WR_PKTEND) r_pkt_count <= r_pkt_count + 16'd1;
    end
  end
`endif

endmodule
